// File: rtl/door_pkg.sv
// Shared state encoding and counter-width helper for the door array controller.
package door_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } door_state_e;

  // Bits needed to hold 0..max_val; never below one so zero-length bounds stay legal.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/door_channel.sv
// One door: mat synchroniser + debounce, motion FSM with position/hold counters.
// Outputs are registered from the next state, so they track the state register exactly.
module door_channel
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TRAVEL_CYCLES   = 8,
  parameter int HOLD_CYCLES     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_mat,
  input  logic obstruct,
  input  logic lock,
  output logic door_open,
  output logic door_closed,
  output logic motor_up,
  output logic motor_dn,
  output logic reopen
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int PW = cnt_width(TRAVEL_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] POS_MAX  = PW'(TRAVEL_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [1:0]    sync;
  logic          demand;
  logic [DW-1:0] deb_cnt;

  door_state_e   state, state_nxt;
  logic [PW-1:0] pos, pos_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic          wake;
  logic          rev;

  // Demand toggles only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '0;
      demand  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync <= {sync[0], sensor_mat};
      if (sync[1] == demand) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        demand  <= ~demand;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    hold_nxt  = hold;
    rev       = 1'b0;
    wake      = demand | obstruct;
    case (state)
      CLOSED: begin
        if (demand && !lock) state_nxt = OPENING;
      end
      OPENING: begin
        if (pos >= POS_MAX - PW'(1)) begin
          pos_nxt   = POS_MAX;
          hold_nxt  = HOLD_MAX;
          state_nxt = OPEN;
        end else begin
          pos_nxt = pos + PW'(1);
        end
      end
      OPEN: begin
        if (wake)                hold_nxt  = HOLD_MAX;
        else if (hold == '0)     state_nxt = CLOSING;
        else                     hold_nxt  = hold - HW'(1);
      end
      CLOSING: begin
        // Reversal is the safety path: it beats the final step and ignores lock.
        if (wake) begin
          state_nxt = OPENING;
          rev       = 1'b1;
        end else if (pos <= PW'(1)) begin
          pos_nxt   = '0;
          state_nxt = CLOSED;
        end else begin
          pos_nxt = pos - PW'(1);
        end
      end
      default: state_nxt = CLOSED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLOSED;
      pos         <= '0;
      hold        <= '0;
      door_open   <= 1'b0;
      door_closed <= 1'b1;
      motor_up    <= 1'b0;
      motor_dn    <= 1'b0;
      reopen      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      hold        <= hold_nxt;
      door_open   <= (state_nxt == OPEN);
      door_closed <= (state_nxt == CLOSED);
      motor_up    <= (state_nxt == OPENING);
      motor_dn    <= (state_nxt == CLOSING);
      reopen      <= rev;
    end
  end

endmodule

// File: rtl/door_array_ctrl.sv
// Array of N_DOORS fully independent door channels sharing only clock and reset.
module door_array_ctrl
  import door_pkg::*;
#(
  parameter int N_DOORS         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TRAVEL_CYCLES   = 8,
  parameter int HOLD_CYCLES     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DOORS-1:0] sensor_mat,
  input  logic [N_DOORS-1:0] obstruct,
  input  logic [N_DOORS-1:0] lock,
  output logic [N_DOORS-1:0] door_open,
  output logic [N_DOORS-1:0] door_closed,
  output logic [N_DOORS-1:0] motor_up,
  output logic [N_DOORS-1:0] motor_dn,
  output logic [N_DOORS-1:0] reopen
);

  for (genvar i = 0; i < N_DOORS; i++) begin : g_door
    door_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .TRAVEL_CYCLES  (TRAVEL_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_door (
      .clk        (clk),
      .rst        (rst),
      .sensor_mat (sensor_mat[i]),
      .obstruct   (obstruct[i]),
      .lock       (lock[i]),
      .door_open  (door_open[i]),
      .door_closed(door_closed[i]),
      .motor_up   (motor_up[i]),
      .motor_dn   (motor_dn[i]),
      .reopen     (reopen[i])
    );
  end

endmodule

// File: tb/tb_door_array_ctrl.sv
// Directed bench: stimulus pushes expected output-change events; a negedge monitor pops and compares.
module tb_door_array_ctrl;

  localparam int N = 2;

  // Output vector encoding: {reopen, motor_dn, motor_up, door_open, door_closed}
  localparam logic [4:0] EC  = 5'b00001;
  localparam logic [4:0] EO  = 5'b00010;
  localparam logic [4:0] EU  = 5'b00100;
  localparam logic [4:0] ED  = 5'b01000;
  localparam logic [4:0] EUR = 5'b10100;

  typedef struct packed {
    int         cyc;
    logic [4:0] outs;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sensor_mat = '0;
  logic [N-1:0] obstruct = '0;
  logic [N-1:0] lock = '0;
  logic [N-1:0] door_open, door_closed, motor_up, motor_dn, reopen;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  q0[$];
  ev_t  q1[$];
  logic [4:0] prev [N];

  door_array_ctrl #(
    .N_DOORS(N), .DEBOUNCE_CYCLES(4), .TRAVEL_CYCLES(8), .HOLD_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .sensor_mat(sensor_mat), .obstruct(obstruct), .lock(lock),
    .door_open(door_open), .door_closed(door_closed), .motor_up(motor_up),
    .motor_dn(motor_dn), .reopen(reopen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int d, input int c, input logic [4:0] o);
    ev_t e;
    e.cyc  = c;
    e.outs = o;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Returns just after the posedge that makes cyc == c.
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_door(input int d, input logic [4:0] v);
    ev_t e;
    int  qs;
    n_checks++;
    if ($countones(v[3:0]) != 1) begin
      n_fail++;
      $display("FAIL onehot door%0d cyc %0d: got %b, required exactly one state bit", d, cyc, v[3:0]);
    end
    if (v !== prev[d]) begin
      prev[d] = v;
      n_checks++;
      qs = (d == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        n_fail++;
        $display("FAIL unexpected door%0d: got %b @cyc %0d, required no change", d, v, cyc);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (v !== e.outs || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL event door%0d: got %b @cyc %0d, required %b @cyc %0d",
                   d, v, cyc, e.outs, e.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < N; d++)
      check_door(d, {reopen[d], motor_dn[d], motor_up[d], door_open[d], door_closed[d]});
  end

  initial begin
    // Reset state for both doors (cycle not checked).
    push(0, -1, EC);
    push(1, -1, EC);
    wait_to(2);
    rst = 1'b0;

    // Basic cycle on door0: mat high cycles 5..24.
    push(0, 12, EU); push(0, 20, EO); push(0, 42, ED); push(0, 50, EC);
    wait_to(5);  sensor_mat[0] = 1'b1;
    wait_to(25); sensor_mat[0] = 1'b0;

    // 3-cycle glitch: no events expected.
    wait_to(55); sensor_mat[0] = 1'b1;
    wait_to(58); sensor_mat[0] = 1'b0;

    // Obstruction during CLOSING at pos=5: reverse, 3-cycle OPENING, full hold.
    push(0, 72, EU); push(0, 80, EO); push(0, 102, ED);
    push(0, 106, EUR); push(0, 107, EU); push(0, 109, EO); push(0, 120, ED); push(0, 128, EC);
    wait_to(65);  sensor_mat[0] = 1'b1;
    wait_to(85);  sensor_mat[0] = 1'b0;
    wait_to(105); obstruct[0] = 1'b1;
    wait_to(106); obstruct[0] = 1'b0;

    // Obstruction on the final CLOSING cycle (pos=1): 7-cycle OPENING.
    push(0, 142, EU); push(0, 150, EO); push(0, 172, ED);
    push(0, 180, EUR); push(0, 181, EU); push(0, 187, EO); push(0, 198, ED); push(0, 206, EC);
    wait_to(135); sensor_mat[0] = 1'b1;
    wait_to(155); sensor_mat[0] = 1'b0;
    wait_to(179); obstruct[0] = 1'b1;
    wait_to(180); obstruct[0] = 1'b0;

    // Lock on door1 while door0 runs a normal cycle alongside.
    push(0, 217, EU); push(0, 225, EO); push(0, 247, ED); push(0, 255, EC);
    push(1, 223, EU); push(1, 231, EO); push(1, 257, ED); push(1, 265, EC);
    wait_to(210); sensor_mat[0] = 1'b1; sensor_mat[1] = 1'b1; lock[1] = 1'b1;
    wait_to(222); lock[1] = 1'b0;
    wait_to(230); sensor_mat[0] = 1'b0;
    wait_to(240); sensor_mat[1] = 1'b0;

    // Reset mid-OPENING at pos=4, then a normal cycle from CLOSED.
    push(0, 277, EU); push(0, 281, EC);
    push(0, 297, EU); push(0, 305, EO); push(0, 327, ED); push(0, 335, EC);
    wait_to(270); sensor_mat[0] = 1'b1;
    wait_to(281); rst = 1'b1; sensor_mat[0] = 1'b0;
    wait_to(283); rst = 1'b0;
    wait_to(290); sensor_mat[0] = 1'b1;
    wait_to(310); sensor_mat[0] = 1'b0;

    wait_to(345);
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL pending door0: got %0d events still expected, required 0", q0.size());
    end
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL pending door1: got %0d events still expected, required 0", q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
